classifier_frame_scheduler: RTL and testbench

//  Time-shares one classifier_Classifier instance between N_CH FFT-magnitude channels (e.g. two mics).

---
 rtl/classifier_sched_pkg.sv | 16 +
 rtl/classifier_rr_arbiter.sv | 47 ++++
 rtl/cmn_EnResetReg.sv | 21 ++
 rtl/classifier_frame_scheduler.sv | 174 +++++++++++++++++
 tb/tb_classifier_frame_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/classifier_sched_pkg.sv
// rtl/classifier_sched_pkg.sv - shared types and helpers for the classifier frame scheduler
package classifier_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    // Channel-id width; a single-bit id is kept even for degenerate channel counts.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/classifier_rr_arbiter.sv
// rtl/classifier_rr_arbiter.sv - combinational round-robin grant from a priority pointer
// Ports: i_req (per-channel request), i_ptr (highest-priority channel),
//        o_gnt (onehot grant), o_idx (granted index), o_any (some request present).
module classifier_rr_arbiter
    import classifier_sched_pkg::*;
#(
    parameter  int N_CH = 2,
    localparam int CH_W = ch_width(N_CH)
) (
    input  logic [N_CH-1:0] i_req,
    input  logic [CH_W-1:0] i_ptr,
    output logic [N_CH-1:0] o_gnt,
    output logic [CH_W-1:0] o_idx,
    output logic            o_any
);

    // Each requester gets a distance from the pointer (wrapping); the smallest wins.
    always_comb begin : arb
        int best_d;
        int best_j;
        int d;
        best_d = N_CH;
        best_j = 0;
        d      = 0;
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        for (int j = 0; j < N_CH; j++) begin
            d = j - int'(i_ptr);
            if (d < 0) begin
                d = d + N_CH;
            end
            if (i_req[j] && (d < best_d)) begin
                best_d = d;
                best_j = j;
            end
        end
        if (best_d < N_CH) begin
            o_any = 1'b1;
            o_idx = CH_W'(best_j);
        end
        for (int j = 0; j < N_CH; j++) begin
            o_gnt[j] = o_any && (j == best_j);
        end
    end

endmodule

// File: rtl/cmn_EnResetReg.sv
// rtl/cmn_EnResetReg.sv - enabled register with synchronous active-high reset to zero
// Ports: clk, reset, en (load enable), d (next value), q (registered value).
module cmn_EnResetReg #(
    parameter int p_nbits = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [p_nbits-1:0] d,
    output logic [p_nbits-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/classifier_frame_scheduler.sv
// rtl/classifier_frame_scheduler.sv - round-robin time-sharing of one classifier among N_CH frame channels
// Ports: recv_* per-channel frame input (val/rdy/msg), cls_recv_* frame to classifier,
//        cls_send_* decision from classifier, send_* tagged decision out (msg, ch, err).
module classifier_frame_scheduler
    import classifier_sched_pkg::*;
#(
    parameter  int BIT_WIDTH = 32,
    parameter  int N_SAMPLES = 8,
    parameter  int N_CH      = 2,
    parameter  int TIMEOUT   = 64,
    localparam int CH_W      = ch_width(N_CH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_CH-1:0]      recv_val,
    output logic [N_CH-1:0]      recv_rdy,
    input  logic [BIT_WIDTH-1:0] recv_msg [N_CH][N_SAMPLES],
    output logic                 cls_recv_val,
    input  logic                 cls_recv_rdy,
    output logic [BIT_WIDTH-1:0] cls_recv_msg [N_SAMPLES],
    input  logic                 cls_send_val,
    output logic                 cls_send_rdy,
    input  logic                 cls_send_msg,
    output logic                 send_val,
    input  logic                 send_rdy,
    output logic                 send_msg,
    output logic [CH_W-1:0]      send_ch,
    output logic                 send_err
);

    localparam int            TW   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

    sched_state_t         r_state;
    sched_state_t         w_state_nxt;
    logic [CH_W-1:0]      r_ptr;
    logic [CH_W-1:0]      r_ch;
    logic [TW-1:0]        r_timer;
    logic                 r_res;
    logic                 r_err;
    logic                 r_stale;

    logic [N_CH-1:0]      w_gnt;
    logic [CH_W-1:0]      w_gnt_idx;
    logic                 w_any;
    logic                 w_recv_fire;
    logic                 w_issue_fire;
    logic                 w_dec_fire;
    logic                 w_timeout;
    logic                 w_stale_drop;
    logic [BIT_WIDTH-1:0] w_frame_sel [N_SAMPLES];

    classifier_rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .i_req (recv_val),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx),
        .o_any (w_any)
    );

    assign w_frame_sel = recv_msg[w_gnt_idx];

    // The frame buffer only loads on a grant, so the classifier sees a stable frame until it is done.
    for (genvar s = 0; s < N_SAMPLES; s++) begin : g_buf
        cmn_EnResetReg #(
            .p_nbits (BIT_WIDTH)
        ) u_reg (
            .clk   (clk),
            .reset (reset),
            .en    (w_recv_fire),
            .d     (w_frame_sel[s]),
            .q     (cls_recv_msg[s])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        recv_rdy     = '0;
        cls_recv_val = 1'b0;
        cls_send_rdy = 1'b0;
        send_val     = 1'b0;
        w_recv_fire  = 1'b0;
        w_issue_fire = 1'b0;
        w_dec_fire   = 1'b0;
        w_timeout    = 1'b0;
        w_stale_drop = 1'b0;
        unique case (r_state)
            IDLE: begin
                recv_rdy     = w_gnt;
                w_recv_fire  = w_any;
                // A decision that outlived its timeout is drained and discarded here.
                cls_send_rdy = r_stale;
                w_stale_drop = r_stale && cls_send_val;
                if (w_any) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                cls_recv_val = 1'b1;
                w_issue_fire = cls_recv_rdy;
                if (cls_recv_rdy) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                cls_send_rdy = 1'b1;
                w_dec_fire   = cls_send_val;
                // A decision on the last allowed cycle takes priority over the timeout.
                w_timeout    = (TIMEOUT != 0) && !cls_send_val && (r_timer == TMAX);
                if (w_dec_fire || w_timeout) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                send_val     = 1'b1;
                cls_send_rdy = r_stale;
                w_stale_drop = r_stale && cls_send_val;
                if (send_rdy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr   <= '0;
            r_ch    <= '0;
            r_timer <= '0;
            r_res   <= 1'b0;
            r_err   <= 1'b0;
            r_stale <= 1'b0;
        end else begin
            if (w_recv_fire) begin
                r_ch  <= w_gnt_idx;
                r_ptr <= (w_gnt_idx == CH_W'(N_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
            if (w_issue_fire) begin
                r_timer <= '0;
            end else if ((r_state == WAIT) && !cls_send_val && (r_timer != '1)) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_dec_fire) begin
                r_res <= cls_send_msg;
                r_err <= 1'b0;
            end
            if (w_timeout) begin
                r_res   <= 1'b0;
                r_err   <= 1'b1;
                r_stale <= 1'b1;
            end else if (w_stale_drop) begin
                r_stale <= 1'b0;
            end
        end
    end

    assign send_msg = r_res;
    assign send_ch  = r_ch;
    assign send_err = r_err;

endmodule

// File: tb/tb_classifier_frame_scheduler.sv
// tb/tb_classifier_frame_scheduler.sv - directed self-checking bench for classifier_frame_scheduler
module tb_classifier_frame_scheduler;

    logic        clk;
    logic        reset;
    logic [1:0]  recv_val;
    logic [1:0]  recv_rdy;
    logic [31:0] recv_msg [2][8];
    logic        cls_recv_val;
    logic        cls_recv_rdy;
    logic [31:0] cls_recv_msg [8];
    logic        cls_send_val;
    logic        cls_send_rdy;
    logic        cls_send_msg;
    logic        send_val;
    logic        send_rdy;
    logic        send_msg;
    logic [0:0]  send_ch;
    logic        send_err;

    int checks = 0;
    int errors = 0;

    classifier_frame_scheduler #(
        .BIT_WIDTH (32),
        .N_SAMPLES (8),
        .N_CH      (2),
        .TIMEOUT   (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .recv_val     (recv_val),
        .recv_rdy     (recv_rdy),
        .recv_msg     (recv_msg),
        .cls_recv_val (cls_recv_val),
        .cls_recv_rdy (cls_recv_rdy),
        .cls_recv_msg (cls_recv_msg),
        .cls_send_val (cls_send_val),
        .cls_send_rdy (cls_send_rdy),
        .cls_send_msg (cls_send_msg),
        .send_val     (send_val),
        .send_rdy     (send_rdy),
        .send_msg     (send_msg),
        .send_ch      (send_ch),
        .send_err     (send_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input int ch, input int s, input int seed);
        return 32'hC0DE_0000 | 32'((seed << 8) | (ch << 4) | s);
    endfunction

    task automatic load_frame(input int ch, input int seed);
        for (int s = 0; s < 8; s++) recv_msg[ch][s] = word(ch, s, seed);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (recv_rdy !== 2'b00) begin errors++; $display("FAIL rst_recv_rdy: got %b want 00", recv_rdy); end
        checks++; if (cls_recv_val !== 1'b0) begin errors++; $display("FAIL rst_cls_recv_val: got %b want 0", cls_recv_val); end
        checks++; if (cls_send_rdy !== 1'b0) begin errors++; $display("FAIL rst_cls_send_rdy: got %b want 0", cls_send_rdy); end
        checks++; if (send_val !== 1'b0) begin errors++; $display("FAIL rst_send_val: got %b want 0", send_val); end
        checks++; if ({send_msg, send_ch, send_err} !== 3'b000) begin errors++; $display("FAIL rst_send_fields: got %b want 000", {send_msg, send_ch, send_err}); end
        checks++; if (cls_recv_msg[0] !== 32'h0) begin errors++; $display("FAIL rst_buffer: got %h want 0", cls_recv_msg[0]); end
        recv_val = 2'b01;
        #1;
        checks++; if (recv_rdy !== 2'b01) begin errors++; $display("FAIL rst_idle_rdy: got %b want 01", recv_rdy); end
        recv_val = 2'b00;
        reset    = 1'b0;
        tick();
    endtask

    task automatic test_single();
        load_frame(0, 1);
        recv_val = 2'b01;
        #1;
        checks++; if (recv_rdy !== 2'b01) begin errors++; $display("FAIL single_rdy: got %b want 01", recv_rdy); end
        tick();
        recv_val = 2'b00;
        #1;
        checks++; if (cls_recv_val !== 1'b1) begin errors++; $display("FAIL single_issue: got %b want 1", cls_recv_val); end
        checks++; if (cls_send_rdy !== 1'b0) begin errors++; $display("FAIL single_issue_srdy: got %b want 0", cls_send_rdy); end
        for (int s = 0; s < 8; s++) begin
            checks++; if (cls_recv_msg[s] !== word(0, s, 1)) begin errors++; $display("FAIL single_frame[%0d]: got %h want %h", s, cls_recv_msg[s], word(0, s, 1)); end
        end
        cls_recv_rdy = 1'b1;
        tick();
        cls_recv_rdy = 1'b0;
        #1;
        checks++; if (cls_send_rdy !== 1'b1) begin errors++; $display("FAIL single_wait_srdy: got %b want 1", cls_send_rdy); end
        checks++; if (cls_recv_val !== 1'b0) begin errors++; $display("FAIL single_wait_val: got %b want 0", cls_recv_val); end
        for (int k = 1; k <= 4; k++) begin
            checks++; if (send_val !== 1'b0) begin errors++; $display("FAIL single_early_send t+%0d: got %b want 0", k, send_val); end
            tick();
        end
        cls_send_val = 1'b1;
        cls_send_msg = 1'b1;
        #1;
        checks++; if (send_val !== 1'b0) begin errors++; $display("FAIL single_early_send t+5: got %b want 0", send_val); end
        tick();
        cls_send_val = 1'b0;
        cls_send_msg = 1'b0;
        #1;
        checks++; if (send_val !== 1'b1) begin errors++; $display("FAIL single_send_val t+6: got %b want 1", send_val); end
        checks++; if ({send_msg, send_ch, send_err} !== 3'b100) begin errors++; $display("FAIL single_send_fields: got %b want 100", {send_msg, send_ch, send_err}); end
        send_rdy = 1'b1;
        tick();
        send_rdy = 1'b0;
        #1;
        checks++; if (send_val !== 1'b0) begin errors++; $display("FAIL single_send_drop: got %b want 0", send_val); end
    endtask

    task automatic test_round_robin();
        logic       e;
        logic [1:0] exp_rdy;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        load_frame(0, 10);
        load_frame(1, 10);
        recv_val = 2'b11;
        for (int k = 0; k < 6; k++) begin
            e       = 1'(k % 2);
            exp_rdy = e ? 2'b10 : 2'b01;
            #1;
            checks++; if (recv_rdy !== exp_rdy) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", k, recv_rdy, exp_rdy); end
            tick();
            checks++; if (recv_rdy !== 2'b00) begin errors++; $display("FAIL rr_issue_rdy[%0d]: got %b want 00", k, recv_rdy); end
            checks++; if (cls_recv_msg[3] !== word(int'(e), 3, 10)) begin errors++; $display("FAIL rr_frame[%0d]: got %h want %h", k, cls_recv_msg[3], word(int'(e), 3, 10)); end
            cls_recv_rdy = 1'b1;
            tick();
            cls_recv_rdy = 1'b0;
            cls_send_val = 1'b1;
            cls_send_msg = e;
            #1;
            checks++; if (recv_rdy !== 2'b00) begin errors++; $display("FAIL rr_wait_rdy[%0d]: got %b want 00", k, recv_rdy); end
            tick();
            cls_send_val = 1'b0;
            #1;
            checks++; if (send_val !== 1'b1) begin errors++; $display("FAIL rr_send_val[%0d]: got %b want 1", k, send_val); end
            checks++; if (send_ch !== e) begin errors++; $display("FAIL rr_send_ch[%0d]: got %b want %b", k, send_ch, e); end
            checks++; if (send_msg !== e) begin errors++; $display("FAIL rr_send_msg[%0d]: got %b want %b", k, send_msg, e); end
            send_rdy = 1'b1;
            tick();
            send_rdy = 1'b0;
        end
        recv_val = 2'b00;
    endtask

    task automatic test_timeout();
        load_frame(0, 3);
        recv_val = 2'b01;
        tick();
        recv_val     = 2'b00;
        cls_recv_rdy = 1'b1;
        tick();
        cls_recv_rdy = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            checks++; if (send_val !== 1'b0) begin errors++; $display("FAIL to_wait_send[%0d]: got %b want 0", k, send_val); end
            checks++; if (cls_send_rdy !== 1'b1) begin errors++; $display("FAIL to_wait_srdy[%0d]: got %b want 1", k, cls_send_rdy); end
            tick();
        end
        #1;
        checks++; if (send_val !== 1'b1) begin errors++; $display("FAIL to_send_val: got %b want 1", send_val); end
        checks++; if ({send_msg, send_ch, send_err} !== 3'b001) begin errors++; $display("FAIL to_send_fields: got %b want 001", {send_msg, send_ch, send_err}); end
        send_rdy = 1'b1;
        tick();
        send_rdy = 1'b0;
        #1;
        checks++; if (cls_send_rdy !== 1'b1) begin errors++; $display("FAIL to_stale_rdy: got %b want 1", cls_send_rdy); end
        cls_send_val = 1'b1;
        cls_send_msg = 1'b1;
        tick();
        cls_send_val = 1'b0;
        cls_send_msg = 1'b0;
        #1;
        checks++; if (send_val !== 1'b0) begin errors++; $display("FAIL to_stale_send: got %b want 0", send_val); end
        checks++; if (cls_send_rdy !== 1'b0) begin errors++; $display("FAIL to_stale_cleared: got %b want 0", cls_send_rdy); end
        checks++; if (cls_recv_val !== 1'b0) begin errors++; $display("FAIL to_stale_idle: got %b want 0", cls_recv_val); end
    endtask

    task automatic test_backpressure();
        load_frame(1, 4);
        recv_val = 2'b10;
        tick();
        recv_val     = 2'b00;
        cls_recv_rdy = 1'b1;
        tick();
        cls_recv_rdy = 1'b0;
        cls_send_val = 1'b1;
        cls_send_msg = 1'b1;
        tick();
        cls_send_val = 1'b0;
        cls_send_msg = 1'b0;
        recv_val     = 2'b11;
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++; if (send_val !== 1'b1) begin errors++; $display("FAIL bp_send_val[%0d]: got %b want 1", k, send_val); end
            checks++; if ({send_msg, send_ch, send_err} !== 3'b110) begin errors++; $display("FAIL bp_fields[%0d]: got %b want 110", k, {send_msg, send_ch, send_err}); end
            checks++; if (recv_rdy !== 2'b00) begin errors++; $display("FAIL bp_recv_rdy[%0d]: got %b want 00", k, recv_rdy); end
            checks++; if (cls_recv_val !== 1'b0) begin errors++; $display("FAIL bp_no_issue[%0d]: got %b want 0", k, cls_recv_val); end
            tick();
        end
        load_frame(0, 5);
        send_rdy = 1'b1;
        tick();
        send_rdy = 1'b0;
        #1;
        checks++; if (recv_rdy !== 2'b01) begin errors++; $display("FAIL bp_next_grant: got %b want 01", recv_rdy); end
    endtask

    task automatic test_hold();
        tick();
        recv_val = 2'b00;
        for (int k = 0; k < 4; k++) begin
            load_frame(0, 6 + k);
            #1;
            checks++; if (cls_recv_val !== 1'b1) begin errors++; $display("FAIL hold_val[%0d]: got %b want 1", k, cls_recv_val); end
            for (int s = 0; s < 8; s++) begin
                checks++; if (cls_recv_msg[s] !== word(0, s, 5)) begin errors++; $display("FAIL hold_frame[%0d][%0d]: got %h want %h", k, s, cls_recv_msg[s], word(0, s, 5)); end
            end
            tick();
        end
        cls_recv_rdy = 1'b1;
        tick();
        cls_recv_rdy = 1'b0;
        #1;
        checks++; if (cls_send_rdy !== 1'b1) begin errors++; $display("FAIL hold_wait: got %b want 1", cls_send_rdy); end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (send_val !== 1'b0) begin errors++; $display("FAIL rm_send_val: got %b want 0", send_val); end
        checks++; if (cls_send_rdy !== 1'b0) begin errors++; $display("FAIL rm_srdy: got %b want 0", cls_send_rdy); end
        checks++; if (cls_recv_val !== 1'b0) begin errors++; $display("FAIL rm_cls_val: got %b want 0", cls_recv_val); end
        recv_val = 2'b11;
        #1;
        checks++; if (recv_rdy !== 2'b01) begin errors++; $display("FAIL rm_ptr: got %b want 01", recv_rdy); end
        recv_val = 2'b10;
        load_frame(1, 7);
        #1;
        checks++; if (recv_rdy !== 2'b10) begin errors++; $display("FAIL rm_ch1_rdy: got %b want 10", recv_rdy); end
        tick();
        recv_val = 2'b00;
        #1;
        checks++; if (cls_recv_msg[7] !== word(1, 7, 7)) begin errors++; $display("FAIL rm_frame: got %h want %h", cls_recv_msg[7], word(1, 7, 7)); end
        cls_recv_rdy = 1'b1;
        tick();
        cls_recv_rdy = 1'b0;
        cls_send_val = 1'b1;
        cls_send_msg = 1'b1;
        tick();
        cls_send_val = 1'b0;
        cls_send_msg = 1'b0;
        #1;
        checks++; if (send_val !== 1'b1) begin errors++; $display("FAIL rm_send_val2: got %b want 1", send_val); end
        checks++; if ({send_msg, send_ch, send_err} !== 3'b110) begin errors++; $display("FAIL rm_fields: got %b want 110", {send_msg, send_ch, send_err}); end
        send_rdy = 1'b1;
        tick();
        send_rdy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        recv_val     = 2'b00;
        cls_recv_rdy = 1'b0;
        cls_send_val = 1'b0;
        cls_send_msg = 1'b0;
        send_rdy     = 1'b0;
        load_frame(0, 0);
        load_frame(1, 0);
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_backpressure();
        test_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
